// File: rtl/pci_target.sv
// PCI memory target: decodes memory read/write cycles hitting its window and
// serves single or burst data phases from a small register file.
module pci_target #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned NUM_WORDS = 4,
  parameter int unsigned ADDR_LSB  = 4
) (
  input  logic        clk,
  input  logic        rst,
  inout  wire  [31:0] ad,
  input  logic [3:0]  c_be,
  input  logic        frame,
  input  logic        irdy,
  output logic        trdy,
  output logic        devsel
);

  localparam int unsigned IDX_W      = ADDR_LSB - 2;
  localparam logic [3:0]  CMD_MEM_RD = 4'b0110;
  localparam logic [3:0]  CMD_MEM_WR = 4'b0111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_BUSY,
    S_WRITE,
    S_READ_TA,
    S_READ,
    S_TURN
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [31:0]        r_mem [NUM_WORDS];
  logic [IDX_W-1:0]   r_idx;
  logic               r_trdy;
  logic               r_devsel;
  logic               r_ad_oe;
  logic               w_hit;
  logic               w_xfer;
  logic               w_latch;
  logic [31:0]        w_rd_data;

  assign w_hit     = (ad[31:ADDR_LSB] == BASE_ADDR[31:ADDR_LSB]);
  assign w_rd_data = r_mem[r_idx];
  assign ad        = r_ad_oe ? w_rd_data : 'z;
  assign trdy      = r_trdy;
  assign devsel    = r_devsel;

  always_comb begin
    w_state_nxt = r_state;
    w_xfer      = 1'b0;
    w_latch     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!frame) begin
          if (w_hit && (c_be == CMD_MEM_WR)) begin
            w_state_nxt = S_WRITE;
            w_latch     = 1'b1;
          end else if (w_hit && (c_be == CMD_MEM_RD)) begin
            w_state_nxt = S_READ_TA;
            w_latch     = 1'b1;
          end else begin
            w_state_nxt = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        if (frame && irdy) w_state_nxt = S_IDLE;
      end
      S_READ_TA: begin
        if (frame && irdy) w_state_nxt = S_IDLE;
        else               w_state_nxt = S_READ;
      end
      S_WRITE, S_READ: begin
        // Bus idle while selected means the initiator abandoned the cycle.
        if (frame && irdy) begin
          w_state_nxt = S_IDLE;
        end else if (!irdy && !r_trdy) begin
          w_xfer = 1'b1;
          if (frame) w_state_nxt = S_TURN;
        end
      end
      S_TURN: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Bus outputs are registered from the next state so they change only at edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_idx    <= '0;
      r_trdy   <= 1'b1;
      r_devsel <= 1'b1;
      r_ad_oe  <= 1'b0;
      for (int unsigned i = 0; i < NUM_WORDS; i++) r_mem[i] <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_devsel <= !((w_state_nxt == S_WRITE) || (w_state_nxt == S_READ_TA) ||
                    (w_state_nxt == S_READ));
      r_trdy   <= !((w_state_nxt == S_WRITE) || (w_state_nxt == S_READ));
      r_ad_oe  <= (w_state_nxt == S_READ);
      if (w_latch) begin
        r_idx <= ad[ADDR_LSB-1:2];
      end else if (w_xfer) begin
        r_idx <= r_idx + 1'b1;
      end
      if (w_xfer && (r_state == S_WRITE)) begin
        for (int unsigned k = 0; k < 4; k++) begin
          if (!c_be[k]) r_mem[r_idx][8*k +: 8] <= ad[8*k +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_pci_target.sv
// Directed bench for pci_target: scoreboard of expected read data, immediate
// assertions at each check, bus release observed against a zero probe.
module tb_pci_target;

  localparam logic [31:0] BASE = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  c_be;
  logic        frame;
  logic        irdy;
  logic        trdy;
  logic        devsel;
  logic [31:0] tb_ad;
  logic        tb_oe;
  wire  [31:0] ad;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model[4];

  assign ad = tb_oe ? tb_ad : 'z;

  pci_target #(
    .BASE_ADDR (BASE),
    .NUM_WORDS (4),
    .ADDR_LSB  (4)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .ad     (ad),
    .c_be   (c_be),
    .frame  (frame),
    .irdy   (irdy),
    .trdy   (trdy),
    .devsel (devsel)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Target must not drive: bench drives a zero probe and expects to read it back.
  task automatic check_released(input string tag);
    tb_ad = '0;
    tb_oe = 1'b1;
    #1;
    check(tag, ad, 32'h0);
  endtask

  task automatic do_write(input int idx, input logic [31:0] data, input logic [3:0] be);
    tb_ad = BASE | (idx << 2);
    tb_oe = 1'b1;
    c_be  = 4'b0111;
    frame = 1'b0;
    irdy  = 1'b1;
    tick();
    tb_ad = data;
    c_be  = be;
    frame = 1'b1;
    irdy  = 1'b0;
    #1;
    check("wr_devsel", devsel, 0);
    check("wr_trdy", trdy, 0);
    tick();
    irdy = 1'b1;
    c_be = 4'h0;
    check_released("wr_turn_ad");
    check("wr_turn_devsel", devsel, 1);
    check("wr_turn_trdy", trdy, 1);
    tb_oe = 1'b0;
    tick();
    for (int k = 0; k < 4; k++) if (!be[k]) model[idx][8*k +: 8] = data[8*k +: 8];
  endtask

  task automatic do_read(input int idx, input int n, input int wp, input int wn);
    int b;
    tb_ad = BASE | (idx << 2);
    tb_oe = 1'b1;
    c_be  = 4'b0110;
    frame = 1'b0;
    irdy  = 1'b1;
    tick();
    c_be  = 4'h0;
    irdy  = 1'b0;
    frame = (n == 1);
    check_released("rd_ta_ad");
    check("rd_ta_devsel", devsel, 0);
    check("rd_ta_trdy", trdy, 1);
    tb_oe = 1'b0;
    for (int p = 0; p < n; p++) begin
      irdy  = 1'b0;
      frame = (p == n - 1);
      #1;
      b = 0;
      while (trdy !== 1'b0 && b < 8) begin
        tick();
        b++;
      end
      check("rd_trdy", trdy, 0);
      if (p == wp) begin
        for (int w = 0; w < wn; w++) begin
          irdy  = 1'b1;
          frame = 1'b0;
          #1;
          check("rd_wait_ad", ad, exp_q[0]);
          check("rd_wait_trdy", trdy, 0);
          tick();
        end
        irdy  = 1'b0;
        frame = (p == n - 1);
        #1;
      end
      check("rd_data", ad, exp_q.pop_front());
      check("rd_devsel", devsel, 0);
      tick();
    end
    irdy  = 1'b1;
    frame = 1'b1;
    check_released("rd_turn_ad");
    check("rd_turn_devsel", devsel, 1);
    check("rd_turn_trdy", trdy, 1);
    tb_oe = 1'b0;
    tick();
    check("rd_idle_devsel", devsel, 1);
  endtask

  task automatic do_ignored(input logic [31:0] addr, input logic [3:0] cmd, input string tag);
    tb_ad = addr;
    tb_oe = 1'b1;
    c_be  = cmd;
    frame = 1'b0;
    irdy  = 1'b1;
    tick();
    irdy  = 1'b0;
    c_be  = 4'h0;
    for (int i = 0; i < 3; i++) begin
      check_released({tag, "_ad"});
      check({tag, "_devsel"}, devsel, 1);
      check({tag, "_trdy"}, trdy, 1);
      tick();
    end
    frame = 1'b1;
    irdy  = 1'b1;
    tb_oe = 1'b0;
    tick();
    check({tag, "_idle_devsel"}, devsel, 1);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) model[i] = '0;
    rst   = 1'b1;
    c_be  = 4'h0;
    frame = 1'b1;
    irdy  = 1'b1;
    tb_ad = '0;
    tb_oe = 1'b0;

    // 1: reset state, then word 0 reads as zero
    tick();
    tick();
    check("rst_trdy", trdy, 1);
    check("rst_devsel", devsel, 1);
    check_released("rst_ad");
    tb_oe = 1'b0;
    rst = 1'b0;
    tick();
    exp_q.push_back(32'h0);
    do_read(0, 1, -1, 0);

    // 2: single write, read back
    do_write(1, 32'hDEAD_BEEF, 4'h0);
    exp_q.push_back(32'hDEAD_BEEF);
    do_read(1, 1, -1, 0);

    // 3: wrapping burst of 5 from word 2 with two wait states on phase 2
    do_write(0, 32'hA0A0_0001, 4'h0);
    do_write(2, 32'h2222_5555, 4'h0);
    do_write(3, 32'h3333_AAAA, 4'h0);
    for (int p = 0; p < 5; p++) exp_q.push_back(model[(2 + p) % 4]);
    do_read(2, 5, 1, 2);

    // 4: byte-enable merge
    do_write(3, 32'hFFFF_FFFF, 4'h0);
    do_write(3, 32'h1122_3344, 4'b1010);
    exp_q.push_back(32'hFF22_FF44);
    do_read(3, 1, -1, 0);

    // 5: address miss and unsupported command are ignored
    do_ignored(BASE + 32'h100, 4'b0110, "miss");
    do_ignored(BASE, 4'b0010, "iocmd");
    exp_q.push_back(32'hDEAD_BEEF);
    do_read(1, 1, -1, 0);

    // 6: reset during a read burst
    tb_ad = BASE | (0 << 2);
    tb_oe = 1'b1;
    c_be  = 4'b0110;
    frame = 1'b0;
    irdy  = 1'b1;
    tick();
    tb_oe = 1'b0;
    c_be  = 4'h0;
    irdy  = 1'b0;
    tick();
    exp_q.push_back(model[0]);
    check("mid_rd_data", ad, exp_q.pop_front());
    tick();
    check("mid_rd_next", ad, model[1]);
    rst = 1'b1;
    tick();
    check("mid_rst_trdy", trdy, 1);
    check("mid_rst_devsel", devsel, 1);
    rst   = 1'b0;
    frame = 1'b1;
    irdy  = 1'b1;
    check_released("mid_rst_ad");
    tb_oe = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) model[i] = '0;
    exp_q.push_back(32'h0);
    do_read(1, 1, -1, 0);

    check("sb_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
